// File: rtl/ip_tx_pkg.sv
// ip_tx_pkg: shared widths, request entry layout and TX FSM states
// for the IP TX request queue and its storage.
package ip_tx_pkg;

  localparam int IP_W   = 32;
  localparam int MAC_W  = 48;
  localparam int MSG_W  = 10;
  localparam int QCNT_W = 5;
  localparam int TXN_W  = 16;

  // Field order matches the packing used in the queue storage.
  typedef struct packed {
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
    logic [MSG_W-1:0] message;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACCEPT,
    WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy count.
// Ports: ACLK, ARESET (sync, high), push/wr_data, pop/rd_data, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;

  // Storage is left unreset; count gates its use.
  always_ff @(posedge ACLK) begin
    if (push) mem[wptr_q] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem[rptr_q];
  assign count   = count_q;

endmodule

// File: rtl/ip_tx_request_queue.sv
// ip_tx_request_queue: buffers accelerator send requests and hands
// them one at a time to the packet TX stage.
// Ports: ACLK/ARESET; REQ_* request handshake in; RECIPIENT_* head
// entry and START_IP_TXN out to TX; READY_FOR_SEND from TX;
// QUEUE_COUNT occupancy, TXN_COUNT completed packets.
module ip_tx_request_queue
  import ip_tx_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int IP_ADDR_WIDTH    = IP_W,
  parameter int MAC_ADDR_WIDTH   = MAC_W,
  parameter int ACCEL_DATA_WIDTH = MSG_W
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic [IP_ADDR_WIDTH-1:0]    REQ_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]   REQ_MAC_ADDRESS,
  input  logic [ACCEL_DATA_WIDTH-1:0] REQ_MESSAGE,
  output logic [IP_ADDR_WIDTH-1:0]    RECIPIENT_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]   RECIPIENT_MAC_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0] RECIPIENT_MESSAGE,
  output logic                        START_IP_TXN,
  input  logic                        READY_FOR_SEND,
  output logic [QCNT_W-1:0]           QUEUE_COUNT,
  output logic [TXN_W-1:0]            TXN_COUNT
);

  localparam int EW = IP_ADDR_WIDTH + MAC_ADDR_WIDTH
                    + ACCEL_DATA_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  tx_state_e      state_q;
  tx_state_e      state_d;
  logic [CW-1:0]  fifo_cnt;
  logic [EW-1:0]  head;
  logic [EW-1:0]  rec_q;
  logic [TXN_W-1:0] txn_cnt_q;
  logic           push;
  logic           pop;
  logic           start;
  logic           has_entry;

  // Ready comes from the registered count only, so a pop in the
  // same cycle never lets a full queue accept.
  assign REQ_READY = ~ARESET & (fifo_cnt < FULL);
  assign push      = REQ_VALID & REQ_READY;
  assign has_entry = (fifo_cnt != '0);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .push    (push),
    .wr_data ({REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE}),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_cnt)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_d_apply: state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (has_entry && READY_FOR_SEND) state_d = LAUNCH;
      LAUNCH:
        state_d = WAIT_ACCEPT;
      WAIT_ACCEPT:
        if (!READY_FOR_SEND) state_d = WAIT_DONE;
      WAIT_DONE:
        if (READY_FOR_SEND) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    pop   = 1'b0;
    unique case (1'b1)
      (state_q == LAUNCH):    start = 1'b1;
      (state_q == WAIT_DONE): pop   = READY_FOR_SEND;
      default: ;
    endcase
  end

  // Head is tracked while idle, frozen for the whole packet, and
  // cleared on the pop edge so an emptied queue shows zero.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rec_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:      rec_q <= has_entry ? head : '0;
        WAIT_DONE: if (pop) rec_q <= '0;
        default:   rec_q <= rec_q;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)   txn_cnt_q <= '0;
    else if (pop) txn_cnt_q <= txn_cnt_q + TXN_W'(1);
  end

  assign {RECIPIENT_IP_ADDRESS,
          RECIPIENT_MAC_ADDRESS,
          RECIPIENT_MESSAGE} = rec_q;

  assign START_IP_TXN = start;
  assign QUEUE_COUNT  = QCNT_W'(fifo_cnt);
  assign TXN_COUNT    = txn_cnt_q;

endmodule

// File: tb/tb_ip_tx_request_queue.sv
// tb_ip_tx_request_queue: directed scoreboard bench with a TX-stage
// model driving READY_FOR_SEND.
module tb_ip_tx_request_queue;
  import ip_tx_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [31:0] REQ_IP_ADDRESS = '0;
  logic [47:0] REQ_MAC_ADDRESS = '0;
  logic [9:0]  REQ_MESSAGE = '0;
  logic [31:0] RECIPIENT_IP_ADDRESS;
  logic [47:0] RECIPIENT_MAC_ADDRESS;
  logic [9:0]  RECIPIENT_MESSAGE;
  logic        START_IP_TXN;
  logic        READY_FOR_SEND = 1'b1;
  logic [4:0]  QUEUE_COUNT;
  logic [15:0] TXN_COUNT;

  int n_chk = 0;
  int n_fail = 0;

  req_entry_t sb[$];
  req_entry_t rec;
  req_entry_t held;
  req_entry_t exp_e;

  int   phase = 0;
  int   cnt = 0;
  int   gap = 0;
  int   starts = 0;
  int   busy_len = 64;
  bit   tx_busy = 1'b0;
  bit   tx_ignore = 1'b0;
  bit   model_rst = 1'b1;
  bit   first = 1'b1;
  bit   seq_ok = 1'b0;
  logic [15:0] tb_txn = '0;

  always #5 ACLK = ~ACLK;

  assign rec = {RECIPIENT_IP_ADDRESS, RECIPIENT_MAC_ADDRESS,
                RECIPIENT_MESSAGE};

  ip_tx_request_queue dut (
    .ACLK                  (ACLK),
    .ARESET                (ARESET),
    .REQ_VALID             (REQ_VALID),
    .REQ_READY             (REQ_READY),
    .REQ_IP_ADDRESS        (REQ_IP_ADDRESS),
    .REQ_MAC_ADDRESS       (REQ_MAC_ADDRESS),
    .REQ_MESSAGE           (REQ_MESSAGE),
    .RECIPIENT_IP_ADDRESS  (RECIPIENT_IP_ADDRESS),
    .RECIPIENT_MAC_ADDRESS (RECIPIENT_MAC_ADDRESS),
    .RECIPIENT_MESSAGE     (RECIPIENT_MESSAGE),
    .START_IP_TXN          (START_IP_TXN),
    .READY_FOR_SEND        (READY_FOR_SEND),
    .QUEUE_COUNT           (QUEUE_COUNT),
    .TXN_COUNT             (TXN_COUNT)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_entry_t mk(input int i);
    req_entry_t e;
    e.ip      = 32'hC0A8_0000 | 32'(i);
    e.mac     = 48'h0200_0000_0000 + 48'(i);
    e.message = 10'(i);
    return e;
  endfunction

  task automatic push(input req_entry_t e, input int max_wait);
    int w = 0;
    @(negedge ACLK);
    REQ_VALID = 1'b1;
    {REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE} = e;
    while (!REQ_READY && w < max_wait) begin
      @(negedge ACLK);
      w++;
    end
    chk("push_ready", REQ_READY, 1'b1);
    if (REQ_READY) sb.push_back(e);
  endtask

  task automatic drop();
    @(negedge ACLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_drain(input int max_wait);
    int w = 0;
    while (!(sb.size() == 0 && phase == 0 && TXN_COUNT === tb_txn)
           && w < max_wait) begin
      @(negedge ACLK);
      w++;
    end
    chk("drain_in_time", w < max_wait, 1'b1);
    @(negedge ACLK);
  endtask

  // TX stage model plus head-entry monitor.
  initial forever begin
    @(negedge ACLK);
    if (model_rst) begin
      model_rst = 1'b0;
      phase = 0;
      cnt = 0;
      gap = 0;
      first = 1'b1;
      seq_ok = 1'b0;
      sb.delete();
      READY_FOR_SEND = 1'b1;
    end else begin
      if (phase == 0) gap++;
      if (START_IP_TXN) begin
        chk("start_spacing",
            (phase == 0) && (first || (seq_ok && gap >= 2)), 1'b1);
        chk("start_has_entry", sb.size() != 0, 1'b1);
        exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("recip_head", rec, exp_e);
        first = 1'b0;
        seq_ok = 1'b0;
        starts++;
        held = rec;
        phase = 1;
      end else begin
        if (phase != 0) chk("recip_stable", rec, held);
        case (phase)
          1: if (!tx_ignore) begin
            READY_FOR_SEND = 1'b0;
            phase = 2;
            cnt = 0;
          end
          2: begin
            cnt++;
            if (cnt >= busy_len) begin
              READY_FOR_SEND = 1'b1;
              seq_ok = 1'b1;
              gap = 0;
              phase = 0;
              tb_txn++;
            end
          end
          default: READY_FOR_SEND = !tx_busy;
        endcase
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int w;
    req_entry_t e;

    // Reset state
    repeat (2) @(negedge ACLK);
    chk("rst_ready", REQ_READY, 1'b0);
    chk("rst_qcnt", QUEUE_COUNT, 5'd0);
    chk("rst_txn", TXN_COUNT, 16'd0);
    chk("rst_start", START_IP_TXN, 1'b0);
    chk("rst_recip", rec, '0);
    ARESET = 1'b0;
    #1;
    chk("ready_after_rst", REQ_READY, 1'b1);

    // Single packet, long TX busy time
    busy_len = 64;
    s0 = starts;
    e.ip = 32'h0A00_0001;
    e.mac = 48'h1122_3344_5566;
    e.message = 10'h2A5;
    push(e, 4);
    drop();
    chk("t1_qcnt_push", QUEUE_COUNT, 5'd1);
    wait_drain(300);
    chk("t1_starts", starts - s0, 1);
    chk("t1_txn", TXN_COUNT, 16'd1);
    chk("t1_qcnt", QUEUE_COUNT, 5'd0);
    chk("t1_recip_empty", rec, '0);

    // Fill to DEPTH with TX busy, then pop/push collision
    busy_len = 8;
    tx_busy = 1'b1;
    s0 = starts;
    @(negedge ACLK);
    for (int i = 1; i <= 4; i++) push(mk(i), 1);
    @(negedge ACLK);
    {REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE} = mk(5);
    chk("t2_full_ready", REQ_READY, 1'b0);
    chk("t2_qcnt_full", QUEUE_COUNT, 5'd4);
    chk("t2_no_start", starts - s0, 0);
    tx_busy = 1'b0;
    w = 0;
    while (!REQ_READY && w < 200) begin
      @(negedge ACLK);
      w++;
    end
    chk("t2_ready_after_pop", REQ_READY, 1'b1);
    chk("t2_accept_after_pop", TXN_COUNT, 16'd2);
    if (REQ_READY) sb.push_back(mk(5));
    drop();
    chk("t2_qcnt_refill", QUEUE_COUNT, 5'd4);
    wait_drain(1000);
    chk("t2_starts", starts - s0, 5);
    chk("t2_txn", TXN_COUNT, 16'd6);
    chk("t2_qcnt", QUEUE_COUNT, 5'd0);

    // Three packets with READY toggling
    busy_len = 5;
    s0 = starts;
    for (int i = 17; i <= 19; i++) push(mk(i), 4);
    drop();
    wait_drain(500);
    chk("t3_starts", starts - s0, 3);
    chk("t3_txn", TXN_COUNT, 16'd9);

    // Missed start: READY never drops in WAIT_ACCEPT
    tx_ignore = 1'b1;
    s0 = starts;
    push(mk(32), 4);
    drop();
    repeat (30) @(negedge ACLK);
    chk("miss_one_start", starts - s0, 1);
    chk("miss_no_pop", TXN_COUNT, 16'd9);
    tx_ignore = 1'b0;
    wait_drain(200);
    chk("miss_txn", TXN_COUNT, 16'd10);

    // Reset during WAIT_DONE with queued entries
    busy_len = 20;
    push(mk(48), 4);
    push(mk(49), 4);
    drop();
    w = 0;
    while (!(phase == 2 && cnt >= 3) && w < 100) begin
      @(negedge ACLK);
      w++;
    end
    chk("t4_reach_wait_done", w < 100, 1'b1);
    chk("t4_qcnt_before", QUEUE_COUNT, 5'd2);
    ARESET = 1'b1;
    model_rst = 1'b1;
    @(negedge ACLK);
    chk("t4_qcnt", QUEUE_COUNT, 5'd0);
    chk("t4_start", START_IP_TXN, 1'b0);
    chk("t4_recip", rec, '0);
    chk("t4_txn", TXN_COUNT, 16'd0);
    chk("t4_ready_in_rst", REQ_READY, 1'b0);
    ARESET = 1'b0;
    tb_txn = '0;
    s0 = starts;
    repeat (30) @(negedge ACLK);
    chk("t4_no_start", starts - s0, 0);
    chk("t4_qcnt_after", QUEUE_COUNT, 5'd0);

    // TXN_COUNT wrap
    force dut.txn_cnt_q = 16'hFFFF;
    #1;
    release dut.txn_cnt_q;
    chk("wrap_preload", TXN_COUNT, 16'hFFFF);
    tb_txn = 16'hFFFF;
    busy_len = 3;
    push(mk(64), 4);
    drop();
    wait_drain(200);
    chk("wrap_zero", TXN_COUNT, 16'd0);
    chk("wrap_qcnt", QUEUE_COUNT, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
